// File: rtl/led_blink_scheduler.sv
// Round-robin scheduler sharing one status LED between three blink requesters.
// Each granted job blinks the LED for a latched count/half-period, then holds it low for a gap.
module led_blink_scheduler #(
  parameter int unsigned TICK_DIV  = 5000,
  parameter int unsigned HP_W      = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [HP_W-1:0] hp0,
  input  logic [HP_W-1:0] hp1,
  input  logic [HP_W-1:0] hp2,
  input  logic [3:0]      blinks0,
  input  logic [3:0]      blinks1,
  input  logic [3:0]      blinks2,
  output logic [2:0]      gnt,
  output logic [2:0]      done,
  output logic            busy,
  output logic            LED
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned GW = $clog2(GAP_TICKS + 1);
  localparam int unsigned CW = (HP_W > GW) ? HP_W : GW;
  localparam int unsigned XW = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

  state_e          state_q, state_d;
  logic            led_q, led_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      done_q, done_d;
  logic            busy_q, busy_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [3:0]      rem_q, rem_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;

  logic            tick;
  logic [XW-1:0]   tcnt_nxt;
  logic [HP_W-1:0] hp_eff;
  logic            hp_last;
  logic            gap_last;
  logic            abort;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic [HP_W-1:0] win_hp;
  logic [3:0]      win_bl;

  // Tick generation and phase-end detection
  always_comb begin
    tick     = (presc_q == PW'(TICK_DIV - 1));
    tcnt_nxt = XW'(tcnt_q) + XW'(1);
    hp_eff   = (hp_q == '0) ? HP_W'(1) : hp_q;
    hp_last  = tick && (tcnt_nxt == XW'(hp_eff));
    gap_last = tick && (tcnt_nxt == XW'(GAP_TICKS));
    abort    = !req[gidx_q];
  end

  // Round-robin search starting after the last winner; lowest offset wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 3; i >= 1; i--) begin
      cand = 2'((32'(ptr_q) + 32'(i)) % 32'd3);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    case (win_idx)
      2'd0:    begin win_hp = hp0; win_bl = blinks0; end
      2'd1:    begin win_hp = hp1; win_bl = blinks1; end
      default: begin win_hp = hp2; win_bl = blinks2; end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    hp_d    = hp_q;
    rem_d   = rem_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    tcnt_d  = tick ? CW'(tcnt_nxt) : tcnt_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        led_d   = 1'b0;
        if (win_found) begin
          gnt_d  = 3'(3'b001 << win_idx);
          ptr_d  = win_idx;
          gidx_d = win_idx;
          hp_d   = win_hp;
          rem_d  = win_bl;
          if (win_bl != 4'd0) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_GAP;
            done_d  = 3'(3'b001 << win_idx);
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_d = S_GAP;
          led_d   = 1'b0;
          presc_d = '0;
          tcnt_d  = '0;
        end else if (hp_last) begin
          state_d = S_OFF;
          led_d   = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d = S_GAP;
          led_d   = 1'b0;
          presc_d = '0;
          tcnt_d  = '0;
        end else if (hp_last) begin
          tcnt_d = '0;
          rem_d  = rem_q - 4'd1;
          if (rem_q != 4'd1) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_GAP;
            done_d  = gnt_q;
          end
        end
      end
      default: begin
        led_d = 1'b0;
        if (gap_last) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          tcnt_d  = '0;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      led_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd2;
      gidx_q  <= '0;
      hp_q    <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      hp_q    <= hp_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign LED  = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with TICK_DIV=4, GAP_TICKS=1.
// Cycle 0 of each run is the first cycle after the grant edge.
module tb_led_blink_scheduler;

  localparam int unsigned HP_W = 8;

  logic            CLOCK_50;
  logic            reset;
  logic [2:0]      req;
  logic [HP_W-1:0] hp0, hp1, hp2;
  logic [3:0]      blinks0, blinks1, blinks2;
  logic [2:0]      gnt, done;
  logic            busy, LED;

  int errors = 0;
  int checks = 0;

  logic [63:0] led_vec;
  logic [2:0]  gnt_log  [0:63];
  logic [2:0]  done_log [0:63];
  logic        busy_log [0:63];
  int          done_total;

  led_blink_scheduler #(
    .TICK_DIV (4),
    .HP_W     (HP_W),
    .GAP_TICKS(1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .req     (req),
    .hp0     (hp0),
    .hp1     (hp1),
    .hp2     (hp2),
    .blinks0 (blinks0),
    .blinks1 (blinks1),
    .blinks2 (blinks2),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .LED     (LED)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected LED bits for nb blinks of hp_c cycles per phase starting at cycle start
  function automatic logic [63:0] blink_vec(input int start, input int hp_c, input int nb);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 2 * nb * hp_c; c++)
      if (((c / hp_c) % 2) == 0) v[start + c] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  // Log n cycles; optionally drop requests on their done pulse and fire one event at ev_c
  task automatic run(input int n, input bit drop_done, input int ev_c,
                     input logic [2:0] ev_clr, input bit ev_scr);
    led_vec    = '0;
    done_total = 0;
    for (int c = 0; c < 64; c++) begin
      gnt_log[c]  = '0;
      done_log[c] = '0;
      busy_log[c] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge CLOCK_50);
      led_vec[c]  = LED;
      gnt_log[c]  = gnt;
      done_log[c] = done;
      busy_log[c] = busy;
      done_total += $countones(done);
      if (drop_done) req = req & ~done;
      if (c == ev_c) begin
        req = req & ~ev_clr;
        if (ev_scr) begin
          hp0     = 8'd1;
          blinks0 = 4'd5;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] exp_v;
    req = '0;
    hp0 = '0; hp1 = '0; hp2 = '0;
    blinks0 = '0; blinks1 = '0; blinks2 = '0;

    // Reset values
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("rst_led",  64'(LED),  64'd0);
    chk("rst_gnt",  64'(gnt),  64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;

    // Single job, with hp0/blinks0 changed mid-job (latched values must be used)
    req = 3'b001; hp0 = 8'd2; blinks0 = 4'd3;
    run(56, 1'b1, 10, 3'b000, 1'b1);
    chk("single_led",   led_vec, blink_vec(0, 8, 3));
    chk("single_done",  64'(done_log[48]), 64'(3'b001));
    chk("single_dcnt",  64'(done_total), 64'd1);
    chk("single_gnt51", 64'(gnt_log[51]), 64'(3'b001));
    chk("single_gnt52", 64'(gnt_log[52]), 64'd0);
    chk("single_bsy51", 64'(busy_log[51]), 64'd1);
    chk("single_bsy52", 64'(busy_log[52]), 64'd0);

    // Round-robin with all three requesting continuously
    do_reset();
    hp0 = 8'd1; hp1 = 8'd1; hp2 = 8'd1;
    blinks0 = 4'd1; blinks1 = 4'd1; blinks2 = 4'd1;
    req = 3'b111;
    run(52, 1'b0, -1, 3'b000, 1'b0);
    req = '0;
    exp_v = blink_vec(0, 4, 1) | blink_vec(13, 4, 1) | blink_vec(26, 4, 1) | blink_vec(39, 4, 1);
    chk("rr_led",   led_vec, exp_v);
    chk("rr_gnt0",  64'(gnt_log[0]),  64'(3'b001));
    chk("rr_idle",  64'(gnt_log[12]), 64'd0);
    chk("rr_gnt1",  64'(gnt_log[13]), 64'(3'b010));
    chk("rr_gnt2",  64'(gnt_log[26]), 64'(3'b100));
    chk("rr_gnt3",  64'(gnt_log[39]), 64'(3'b001));
    chk("rr_done0", 64'(done_log[8]),  64'(3'b001));
    chk("rr_done1", 64'(done_log[21]), 64'(3'b010));
    chk("rr_done2", 64'(done_log[34]), 64'(3'b100));

    // Zero blinks: done on the grant edge, LED stays low, 4-cycle gap
    do_reset();
    hp1 = 8'd5; blinks1 = 4'd0;
    req = 3'b010;
    run(8, 1'b1, -1, 3'b000, 1'b0);
    chk("zb_gnt",   64'(gnt_log[0]),  64'(3'b010));
    chk("zb_done",  64'(done_log[0]), 64'(3'b010));
    chk("zb_done1", 64'(done_log[1]), 64'd0);
    chk("zb_led",   led_vec, 64'd0);
    chk("zb_gnt3",  64'(gnt_log[3]),  64'(3'b010));
    chk("zb_gnt4",  64'(gnt_log[4]),  64'd0);
    chk("zb_busy4", 64'(busy_log[4]), 64'd0);

    // Zero half-period behaves as one tick
    hp2 = 8'd0; blinks2 = 4'd1;
    req = 3'b100;
    run(16, 1'b1, -1, 3'b000, 1'b0);
    chk("zh_led",   led_vec, blink_vec(0, 4, 1));
    chk("zh_done",  64'(done_log[8]), 64'(3'b100));
    chk("zh_gnt12", 64'(gnt_log[12]), 64'd0);

    // Abort 3 cycles into the second ON phase; pending req[1] served after the gap
    do_reset();
    hp0 = 8'd1; blinks0 = 4'd3; hp1 = 8'd1; blinks1 = 4'd1;
    req = 3'b011;
    run(30, 1'b1, 10, 3'b001, 1'b0);
    exp_v = (blink_vec(0, 4, 2) & 64'h7FF) | blink_vec(16, 4, 1);
    chk("ab_led",   led_vec, exp_v);
    chk("ab_dcnt",  64'(done_total), 64'd1);
    chk("ab_done1", 64'(done_log[24]), 64'(3'b010));
    chk("ab_gnt14", 64'(gnt_log[14]), 64'(3'b001));
    chk("ab_gnt15", 64'(gnt_log[15]), 64'd0);
    chk("ab_gnt16", 64'(gnt_log[16]), 64'(3'b010));

    // Asynchronous reset during OFF, then pointer restart
    do_reset();
    hp0 = 8'd2; blinks0 = 4'd3;
    req = 3'b001;
    run(11, 1'b0, -1, 3'b000, 1'b0);
    chk("mr_gnt_pre",  64'(gnt_log[10]), 64'(3'b001));
    chk("mr_busy_pre", 64'(busy_log[10]), 64'd1);
    chk("mr_led_pre",  64'(led_vec[10]), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("mr_led",  64'(LED),  64'd0);
    chk("mr_gnt",  64'(gnt),  64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    hp1 = 8'd1; blinks1 = 4'd1;
    req = 3'b110;
    run(4, 1'b0, -1, 3'b000, 1'b0);
    req = '0;
    chk("mr_regnt", 64'(gnt_log[0]), 64'(3'b010));
    chk("mr_reled", 64'(led_vec[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Shares the board's single status LED between three requesters, such as a heartbeat, an error flag and a user event. Each requester asks for a burst of blinks with its own half-period. The block grants the LED round-robin, generates the blink waveform from an internal prescaler on CLOCK_50, and reports completion per requester. It sits between requester logic and the LED pin, and replaces a free-running toggle divider.

## Interface
- TICK_DIV, default 5000: CLOCK_50 cycles per tick. Legal values are 2 or more.
- HP_W, default 8: width of each half-period input, in ticks.
- GAP_TICKS, default 1: ticks the LED is held low after each job before the next grant. Legal values are 1 or more.

Ports:
- CLOCK_50  in  1  system clock. All logic is on the rising edge.
- reset  in  1  asynchronous reset, active low. The name is kept as is; the level is active low.
- req  in  3  request per requester. Held high until the matching done pulse.
- hp0, hp1, hp2  in  HP_W each  half-period in ticks for each requester. A value of 0 is treated as 1.
- blinks0, blinks1, blinks2  in  4 each  number of on/off blink pairs for each requester.
- gnt  out  3  one-hot grant, high for the whole job including the gap.
- done  out  3  one-cycle pulse when a requester's blink count completes.
- busy  out  1  high in every state except IDLE.
- LED  out  1  LED drive, registered.

## Operation
- States: IDLE, ON, OFF, GAP.
- Reset (reset=0) forces the following, asynchronously:
  - state IDLE; LED=0; gnt=0; done=0; busy=0;
  - prescaler=0; tick counter=0;
  - round-robin pointer=2, so req[0] has first priority.
- Arbitration happens in IDLE only:
  - The search order starts at pointer+1 modulo 3.
  - The first requester found with req high wins.
  - At the grant edge: gnt is set one-hot, pointer is set to the winner, and hp and blinks are latched into internal registers. Later changes on those inputs are ignored.
- Grant with latched blinks≠0: go to ON, LED=1, prescaler and tick counter cleared.
- Grant with latched blinks=0: go straight to GAP, LED stays 0, done pulses on the grant edge.
- Prescaler: counts 0 to TICK_DIV-1 and wraps. A tick is asserted when it equals TICK_DIV-1. The tick counter increments on each tick.
- ON: when the tick counter reaches hp (with 0 read as 1), go to OFF, LED=0, tick counter cleared.
- OFF: when the tick counter reaches hp, decrement the remaining-blink count.
  - If the count is still non-zero: go to ON, LED=1.
  - Otherwise: done[g] pulses, then go to GAP.
- GAP: LED=0. After GAP_TICKS ticks, go to IDLE and clear gnt.
- Abort: if req[g] falls in ON or OFF, the block goes to GAP on the next edge with LED=0 and issues no done.
- A req that falls during GAP is ignored; the gap runs to completion.
- Requests from non-granted requesters never preempt the current job. They wait for IDLE.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives gnt and LED=1 after edge k. The first LED-high cycle is the cycle after the request is sampled.
- Phase lengths:
  - each ON phase and each OFF phase lasts exactly max(hp,1)×TICK_DIV cycles;
  - a job of n blinks drives LED for 2·n·max(hp,1)·TICK_DIV cycles.
- done pulse: asserted for the single cycle in which the state leaves OFF for the last time. It coincides with the first GAP cycle.
- Gap: lasts GAP_TICKS×TICK_DIV cycles, then gnt drops.
- Back-to-back jobs: the earliest next grant is the cycle after IDLE is re-entered. LED is therefore low for at least GAP_TICKS×TICK_DIV+1 cycles between jobs.
- Reset asserted mid-job: immediate return to reset values. No done is issued.

## Test plan
- Parameters for all scenarios: TICK_DIV=4, GAP_TICKS=1.
- Single job: req[0]=1, hp0=2, blinks0=3. Required response:
  - LED high 8 cycles, low 8, repeated 3 times;
  - done[0] pulses once, 48 cycles after the first LED-high cycle;
  - gnt[0] drops 4 cycles later; busy then falls.
- Round-robin: req=3'b111 held, with hp=1 and blinks=1 for all requesters. Required response:
  - grant order 0, 1, 2, 0;
  - each job is 8 LED cycles plus a 4-cycle gap, plus the 1 IDLE cycle before the next grant.
- Zero cases:
  - blinks1=0 with req[1]=1: done[1] pulses on the grant edge, LED stays 0, the 4-cycle gap follows.
  - hp2=0, blinks2=1: behaves exactly as hp2=1 (LED high 4 cycles, low 4).
- Abort: req[0] dropped 3 cycles into the second ON phase of a 3-blink job. Required response:
  - LED goes 0 on the next edge;
  - no done[0];
  - GAP is entered; a pending req[1] is granted after the gap.
- Reset mid-job: reset pulled low during OFF. Required response:
  - LED, gnt, done and busy go to 0 immediately, without waiting for a clock edge;
  - after release with req=3'b110, req[1] is granted first, since the pointer reset value is 2.
- Input stability: change hp0 and blinks0 during an active job. The waveform is unchanged and uses the values latched at grant.
